// File: rtl/spi_slave_core_if.sv
// Pins, configuration and FIFO handshakes of the SPI target core.
// crc_o exists only when SPI_SLV_CRC8_EN is defined.
interface spi_slave_core_if;
   logic        cpol_i;
   logic        cpha_i;
   logic        lsb_i;
   logic [1:0]  dtb_i;
   logic        en_i;
   logic        spi_sck_i;
   logic        spi_nss_i;
   logic        spi_mosi_i;
   logic        spi_miso_o;
   logic        spi_miso_en_o;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [31:0] tx_data_i;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic [31:0] rx_data_o;
   logic        busy_o;
   logic        ovr_o;
   logic        udr_o;
   logic        fre_o;
`ifdef SPI_SLV_CRC8_EN
   logic [7:0]  crc_o;
`endif

   modport slave (
`ifdef SPI_SLV_CRC8_EN
      output crc_o,
`endif
      input  cpol_i, cpha_i, lsb_i, dtb_i, en_i,
      input  spi_sck_i, spi_nss_i, spi_mosi_i,
      output spi_miso_o, spi_miso_en_o,
      input  tx_valid_i, tx_data_i,
      output tx_ready_o,
      output rx_valid_o, rx_data_o,
      input  rx_ready_i,
      output busy_o, ovr_o, udr_o, fre_o
   );

   modport master (
`ifdef SPI_SLV_CRC8_EN
      input  crc_o,
`endif
      output cpol_i, cpha_i, lsb_i, dtb_i, en_i,
      output spi_sck_i, spi_nss_i, spi_mosi_i,
      input  spi_miso_o, spi_miso_en_o,
      output tx_valid_i, tx_data_i,
      input  tx_ready_o,
      input  rx_valid_o, rx_data_o,
      output rx_ready_i,
      input  busy_o, ovr_o, udr_o, fre_o
   );
endinterface

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples SCK/NSS/MOSI in clk_i, exchanges words over valid/ready.
// Optional CRC-8 over received MOSI bits when SPI_SLV_CRC8_EN is defined.
module spi_slave_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   spi_slave_core_if.slave bus
);
   // state   | meaning
   // S_IDLE  | waiting for NSS fall with en_i high; MISO tri-stated
   // S_LOAD  | one cycle: fetch first TX word, present its first bit
   // S_SHIFT | frame active: sample MOSI / advance MISO on SCK edges
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_nss_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_q;
   logic                   r_nss_q;
   logic                   r_cpol;
   logic                   r_cpha;
   logic                   r_lsb;
   logic [1:0]             r_dtb;
   logic [4:0]             r_cnt;
   logic [4:0]             r_idx;
   logic [31:0]            r_rx_sr;
   logic [31:0]            r_txw;
   logic [31:0]            r_rx_data;
   logic                   r_fetch;
   logic                   r_miso;
   logic                   r_rx_valid;
   logic                   r_ovr;
   logic                   r_udr;
   logic                   r_fre;

   logic                   w_sck_s;
   logic                   w_nss_s;
   logic                   w_mosi_s;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_lead;
   logic                   w_trail;
   logic                   w_start;
   logic                   w_abort;
   logic                   w_in_shift;
   logic                   w_sample;
   logic                   w_shift;
   logic                   w_last;
   logic                   w_fetch;
   logic                   w_pop;
   logic                   w_udr;
   logic [4:0]             w_lm1;
   logic [31:0]            w_new_word;
   logic [31:0]            w_rx_next;

   function automatic logic bit_sel(input logic [31:0] word, input logic [4:0] idx,
                                    input logic lsb, input logic [4:0] lm1);
      logic [4:0] pos;
      pos = lsb ? idx : 5'(lm1 - idx);
      return word[pos];
   endfunction

   assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
   assign w_nss_s  = r_nss_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise   = w_sck_s & ~r_sck_q;
   assign w_fall   = ~w_sck_s & r_sck_q;
   assign w_lead   = r_cpol ? w_fall : w_rise;
   assign w_trail  = r_cpol ? w_rise : w_fall;

   // len-1 = 8*dtb+7, so the last bit index is just {dtb, 3'b111}
   assign w_lm1      = {r_dtb, 3'b111};
   assign w_start    = bus.en_i & ~w_nss_s & r_nss_q;
   assign w_abort    = (r_state != S_IDLE) & (w_nss_s | ~bus.en_i);
   assign w_in_shift = (r_state == S_SHIFT) & ~w_abort;
   assign w_sample   = w_in_shift & (r_cpha ? w_trail : w_lead);
   assign w_shift    = w_in_shift & (r_cpha ? w_lead : w_trail);
   assign w_last     = w_sample & (r_cnt == w_lm1);
   assign w_new_word = bus.tx_valid_i ? bus.tx_data_i : 32'd0;
   assign w_pop      = w_fetch & bus.tx_valid_i;
   assign w_udr      = w_fetch & ~bus.tx_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
         S_LOAD:  begin
            w_fetch     = ~w_abort;
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: w_fetch = w_shift & r_fetch;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_rx_next = {r_rx_sr[30:0], w_mosi_s};
      if (r_lsb) begin
         w_rx_next        = r_rx_sr >> 1;
         w_rx_next[w_lm1] = w_mosi_s;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sck_sync  <= '0;
         r_nss_sync  <= '1;
         r_mosi_sync <= '0;
         r_sck_q     <= 1'b0;
         r_nss_q     <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck_i};
         r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], bus.spi_nss_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
         r_sck_q     <= w_sck_s;
         r_nss_q     <= w_nss_s;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_lsb      <= 1'b0;
         r_dtb      <= 2'd0;
         r_cnt      <= 5'd0;
         r_idx      <= 5'd0;
         r_rx_sr    <= 32'd0;
         r_txw      <= 32'd0;
         r_rx_data  <= 32'd0;
         r_fetch    <= 1'b0;
         r_miso     <= 1'b0;
         r_rx_valid <= 1'b0;
         r_ovr      <= 1'b0;
         r_udr      <= 1'b0;
         r_fre      <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         r_fre <= 1'b0;
         r_udr <= w_udr;
         if (r_rx_valid && bus.rx_ready_i) r_rx_valid <= 1'b0;
         if (r_state == S_IDLE && w_start) begin
            r_cpol <= bus.cpol_i;
            r_cpha <= bus.cpha_i;
            r_lsb  <= bus.lsb_i;
            r_dtb  <= bus.dtb_i;
         end
         if (w_abort) begin
            r_fre   <= (r_cnt != 5'd0);
            r_cnt   <= 5'd0;
            r_fetch <= 1'b0;
         end
         if (r_state == S_LOAD && !w_abort) begin
            r_rx_sr <= 32'd0;
            r_cnt   <= 5'd0;
            r_fetch <= 1'b0;
            r_txw   <= w_new_word;
            r_miso  <= bit_sel(w_new_word, 5'd0, r_lsb, w_lm1);
            // cpha=1 re-drives bit 0 on the first leading edge
            r_idx   <= r_cpha ? 5'd0 : 5'd1;
         end
         if (w_sample) begin
            r_rx_sr <= w_last ? 32'd0 : w_rx_next;
            r_cnt   <= w_last ? 5'd0 : r_cnt + 5'd1;
            if (w_last) begin
               r_fetch <= 1'b1;
               if (!r_rx_valid || bus.rx_ready_i) begin
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
               end else begin
                  r_ovr <= 1'b1;
               end
            end
         end
         if (w_shift) begin
            if (r_fetch) begin
               r_txw   <= w_new_word;
               r_miso  <= bit_sel(w_new_word, 5'd0, r_lsb, w_lm1);
               r_idx   <= 5'd1;
               r_fetch <= 1'b0;
            end else begin
               r_miso <= bit_sel(r_txw, r_idx, r_lsb, w_lm1);
               r_idx  <= (r_idx == w_lm1) ? 5'd0 : r_idx + 5'd1;
            end
         end
      end
   end

`ifdef SPI_SLV_CRC8_EN
   logic [7:0] r_crc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_crc <= 8'd0;
      end else if (r_state == S_LOAD && !w_abort) begin
         r_crc <= 8'd0;
      end else if (w_sample) begin
         r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ w_mosi_s) ? 8'h07 : 8'h00);
      end
   end

   assign bus.crc_o = r_crc;
`endif

   assign bus.spi_miso_o    = r_miso;
   assign bus.spi_miso_en_o = (r_state != S_IDLE);
   assign bus.busy_o        = (r_state != S_IDLE);
   assign bus.tx_ready_o    = w_pop;
   assign bus.rx_valid_o    = r_rx_valid;
   assign bus.rx_data_o     = r_rx_data;
   assign bus.ovr_o         = r_ovr;
   assign bus.udr_o         = r_udr;
   assign bus.fre_o         = r_fre;
endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: bench acts as SPI master, TX FIFO and RX consumer.
// CRC checks are active when SPI_SLV_CRC8_EN is defined.
module tb_spi_slave_core;
   localparam int SYNC = 2;
   localparam int HALF = 4;
   localparam int CLKP = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_slave_core_if u_if();
   spi_slave_core #(.SYNC_STAGES(SYNC)) u_dut (.clk_i(clk), .rst_i(rst), .bus(u_if));

   int          total = 0;
   int          bad = 0;
   logic [31:0] tx_q[$];
   logic [31:0] rx_exp[$];
   logic [31:0] mosi_q[$];
   logic [31:0] miso_q[$];
   logic [31:0] tx_exp[$];
   bit          tx_starve = 1'b0;
   int          rx_mode = 1;
   bit          pop_flag = 1'b0;
   bit          prev_valid = 1'b0;
   int          n_pop = 0, n_udr = 0, n_ovr = 0, n_fre = 0;
   longint      t_last_sample = 0, t_rx_rise = 0;
   logic [7:0]  crc_m = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   function automatic logic [31:0] len_mask(input int len);
      return (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
   endfunction

   task automatic clr_cnt();
      n_pop = 0; n_udr = 0; n_ovr = 0; n_fre = 0;
   endtask

   // Compare process: RX stream against the expected word queue, pulse bookkeeping.
   initial begin
      u_if.rx_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            case (rx_mode)
               0:       u_if.rx_ready_i = ($urandom_range(0, 1) == 1);
               1:       u_if.rx_ready_i = 1'b0;
               default: u_if.rx_ready_i = 1'b1;
            endcase
            if (u_if.rx_valid_o && u_if.rx_ready_i) begin
               if (rx_exp.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rx_unexpected: got %h want none", u_if.rx_data_o);
               end else begin
                  chk("rx_word", u_if.rx_data_o, rx_exp.pop_front());
               end
            end
            if (u_if.rx_valid_o && !prev_valid) t_rx_rise = $time;
            prev_valid = u_if.rx_valid_o;
            if (u_if.spi_miso_en_o !== u_if.busy_o) begin
               total++; bad++;
               $display("FAIL miso_en_vs_busy: got %b want %b", u_if.spi_miso_en_o, u_if.busy_o);
            end
            n_pop += int'(u_if.tx_ready_o);
            n_udr += int'(u_if.udr_o);
            n_ovr += int'(u_if.ovr_o);
            n_fre += int'(u_if.fre_o);
            pop_flag = u_if.tx_ready_o;
         end
      end
   end

   // TX FIFO model
   initial begin
      u_if.tx_valid_i = 1'b0;
      u_if.tx_data_i  = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (pop_flag && tx_q.size() > 0) void'(tx_q.pop_front());
         u_if.tx_valid_i = !tx_starve && (tx_q.size() > 0);
         u_if.tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 32'd0;
      end
   end

   task automatic sck_half();
      repeat (HALF) @(negedge clk);
   endtask

   // SPI master: sends mosi_q, collects MISO words into miso_q; stop_edges>0 aborts the frame.
   task automatic master_frame(input bit cpol, input bit cpha, input bit lsb,
                               input logic [1:0] dtb, input int stop_edges);
      int          len;
      int          edges;
      int          pos;
      bit          stop;
      logic [31:0] cur;
      logic [31:0] mw;
      logic        mb;
      logic        rb;
      len   = 8 * (int'(dtb) + 1);
      edges = 0;
      stop  = 1'b0;
      miso_q.delete();
      crc_m = 8'd0;
      u_if.cpol_i = cpol; u_if.cpha_i = cpha; u_if.lsb_i = lsb; u_if.dtb_i = dtb;
      u_if.spi_sck_i = cpol;
      sck_half();
      u_if.spi_nss_i = 1'b0;
      repeat (8) @(negedge clk);
      for (int w = 0; w < mosi_q.size() && !stop; w++) begin
         cur = mosi_q[w];
         mw  = 32'd0;
         for (int b = 0; b < len && !stop; b++) begin
            pos = lsb ? b : len - 1 - b;
            mb  = cur[pos];
            rb  = 1'b0;
            if (!cpha) begin
               u_if.spi_mosi_i = mb;
               sck_half();
               rb = u_if.spi_miso_o;
               u_if.spi_sck_i = ~cpol;
               t_last_sample = $time;
               crc_m = crc_step(crc_m, mb);
               edges++;
               if (edges == stop_edges) stop = 1'b1;
               else begin
                  sck_half();
                  u_if.spi_sck_i = cpol;
                  edges++;
                  if (edges == stop_edges) stop = 1'b1;
               end
            end else begin
               sck_half();
               u_if.spi_sck_i  = ~cpol;
               u_if.spi_mosi_i = mb;
               edges++;
               if (edges == stop_edges) stop = 1'b1;
               else begin
                  sck_half();
                  rb = u_if.spi_miso_o;
                  u_if.spi_sck_i = cpol;
                  t_last_sample = $time;
                  crc_m = crc_step(crc_m, mb);
                  edges++;
                  if (edges == stop_edges) stop = 1'b1;
               end
            end
            mw[pos] = rb;
         end
         if (!stop) miso_q.push_back(mw);
      end
      sck_half();
      u_if.spi_nss_i = 1'b1;
      u_if.spi_sck_i = cpol;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout want finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int          nw;
      int          len;
      bit          cp, ch, lb;
      logic [1:0]  dt;
      logic [31:0] wd;
      u_if.cpol_i = 1'b0; u_if.cpha_i = 1'b0; u_if.lsb_i = 1'b0; u_if.dtb_i = 2'd0;
      u_if.en_i = 1'b0; u_if.spi_sck_i = 1'b0; u_if.spi_nss_i = 1'b1; u_if.spi_mosi_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_flags", 32'({u_if.busy_o, u_if.spi_miso_en_o, u_if.spi_miso_o, u_if.tx_ready_o,
                              u_if.rx_valid_o, u_if.ovr_o, u_if.udr_o, u_if.fre_o}), 32'd0);
      chk("reset_rx_data", u_if.rx_data_o, 32'd0);
`ifdef SPI_SLV_CRC8_EN
      chk("reset_crc", 32'(u_if.crc_o), 32'd0);
`endif
      rst = 1'b0;
      u_if.en_i = 1'b1;
      repeat (4) @(negedge clk);

      // Mode 0, 8-bit, msb-first: A5 in, 3C out; trailing-edge fetch after the word underruns
      clr_cnt(); rx_mode = 1;
      tx_q.push_back(32'h3C);
      mosi_q = '{32'hA5};
      master_frame(1'b0, 1'b0, 1'b0, 2'd0, 0);
      chk("t1_miso", miso_q[0], 32'h3C);
      chk("t1_rx_valid", 32'(u_if.rx_valid_o), 32'd1);
      chk("t1_rx_data", u_if.rx_data_o, 32'hA5);
      chk("t1_pops", 32'(n_pop), 32'd1);
      chk("t1_udr", 32'(n_udr), 32'd1);
      chk("t1_latency_ok", 32'((t_rx_rise - t_last_sample) <= longint'((SYNC + 2) * CLKP)), 32'd1);
      chk("t1_busy_after", 32'(u_if.busy_o), 32'd0);
      rx_exp.push_back(32'hA5);
      rx_mode = 2;
      repeat (4) @(negedge clk);
      chk("t1_drained", 32'(rx_exp.size()), 32'd0);
      chk("t1_rx_cleared", 32'(u_if.rx_valid_o), 32'd0);

      // Mode 3, 32-bit, lsb-first
      clr_cnt();
      tx_q.push_back(32'hDEADBEEF);
      rx_exp.push_back(32'h12345678);
      mosi_q = '{32'h12345678};
      master_frame(1'b1, 1'b1, 1'b1, 2'd3, 0);
      chk("t2_miso", miso_q[0], 32'hDEADBEEF);
      chk("t2_rx_data", u_if.rx_data_o, 32'h12345678);
      chk("t2_pops", 32'(n_pop), 32'd1);
      chk("t2_udr", 32'(n_udr), 32'd0);
      chk("t2_drained", 32'(rx_exp.size()), 32'd0);

      // Overrun: two words, consumer stalled
      clr_cnt(); rx_mode = 1;
      tx_q.push_back(32'h01); tx_q.push_back(32'h02); tx_q.push_back(32'h03);
      mosi_q = '{32'h11, 32'h22};
      master_frame(1'b0, 1'b0, 1'b0, 2'd0, 0);
      chk("t3_rx_valid", 32'(u_if.rx_valid_o), 32'd1);
      chk("t3_rx_kept", u_if.rx_data_o, 32'h11);
      chk("t3_ovr", 32'(n_ovr), 32'd1);
      chk("t3_pops", 32'(n_pop), 32'd3);
      chk("t3_miso1", miso_q[1], 32'h02);
      rx_exp.push_back(32'h11);
      rx_mode = 2;
      repeat (4) @(negedge clk);
      chk("t3_drained", 32'(rx_exp.size()), 32'd0);

      // Underrun: no TX word at frame start
      clr_cnt(); tx_starve = 1'b1;
      rx_exp.push_back(32'h5A);
      mosi_q = '{32'h5A};
      master_frame(1'b0, 1'b0, 1'b0, 2'd0, 0);
      chk("t4_miso_zero", miso_q[0], 32'h0);
      chk("t4_udr", 32'(n_udr), 32'd2);
      chk("t4_pops", 32'(n_pop), 32'd0);
      chk("t4_drained", 32'(rx_exp.size()), 32'd0);
      tx_starve = 1'b0;

      // Frame error: NSS released after 5 SCK edges of a 16-bit word
      clr_cnt();
      tx_q.push_back(32'h1234);
      mosi_q = '{32'hABCD};
      master_frame(1'b0, 1'b0, 1'b0, 2'd1, 5);
      chk("t5_fre", 32'(n_fre), 32'd1);
      chk("t5_rx_valid", 32'(u_if.rx_valid_o), 32'd0);
      chk("t5_busy", 32'(u_if.busy_o), 32'd0);
      chk("t5_miso_en", 32'(u_if.spi_miso_en_o), 32'd0);
      chk("t5_pops", 32'(n_pop), 32'd1);

`ifdef SPI_SLV_CRC8_EN
      clr_cnt();
      tx_q.push_back(32'h00); tx_q.push_back(32'h00);
      rx_exp.push_back(32'h31);
      mosi_q = '{32'h31};
      master_frame(1'b0, 1'b0, 1'b0, 2'd0, 0);
      chk("crc_literal", 32'(u_if.crc_o), 32'h97);
      chk("crc_model", 32'(u_if.crc_o), 32'(crc_m));
`endif

      // Randomized frames against the queue model
      rx_mode = 0;
      for (int it = 0; it < 12; it++) begin
         clr_cnt();
         cp = 1'($urandom_range(0, 1));
         ch = 1'($urandom_range(0, 1));
         lb = 1'($urandom_range(0, 1));
         dt = 2'($urandom_range(0, 3));
         nw = $urandom_range(1, 3);
         len = 8 * (int'(dt) + 1);
         mosi_q.delete(); tx_exp.delete();
         for (int k = 0; k < nw + (ch ? 0 : 1); k++) begin
            wd = $urandom() & len_mask(len);
            tx_q.push_back(wd);
            if (k < nw) tx_exp.push_back(wd);
         end
         for (int k = 0; k < nw; k++) begin
            wd = $urandom() & len_mask(len);
            mosi_q.push_back(wd);
            rx_exp.push_back(wd);
         end
         master_frame(cp, ch, lb, dt, 0);
         repeat (40) @(negedge clk);
         for (int k = 0; k < nw; k++) chk("rnd_miso", miso_q[k], tx_exp[k]);
         chk("rnd_pops", 32'(n_pop), 32'(nw + (ch ? 0 : 1)));
         chk("rnd_errs", 32'(n_udr + n_ovr + n_fre), 32'd0);
         chk("rnd_drained", 32'(rx_exp.size()), 32'd0);
`ifdef SPI_SLV_CRC8_EN
         chk("rnd_crc", 32'(u_if.crc_o), 32'(crc_m));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- SPI target (slave) engine: the far end of the SPI master controller, used for loopback verification and as a device-side SPI port on the same bus.
- Oversamples the external SCK, NSS and MOSI lines in the system clock domain, deserialises MOSI into words and serialises MISO from a TX word stream.
- Exchanges words with surrounding FIFOs through valid/ready handshakes.
- Supports standard single-line mode only, all four CPOL/CPHA modes, MSB/LSB first, and 8/16/24/32-bit words.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on spi_sck_i, spi_nss_i and spi_mosi_i (minimum 2).

Ports:
clk_i  in  1  system clock; must run at least 6x f_sck.
rst_i  in  1  asynchronous reset, active-high.
cpol_i  in  1  idle clock level.
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
lsb_i  in  1  1: LSB first.
dtb_i  in  2  word length: 0=8, 1=16, 2=24, 3=32 bits.
en_i  in  1  core enable; 0 holds the core idle and tri-states MISO.
spi_sck_i  in  1  external SCK.
spi_nss_i  in  1  external chip select, active-low.
spi_mosi_i  in  1  external MOSI.
spi_miso_o  out  1  MISO data.
spi_miso_en_o  out  1  MISO output enable.
tx_valid_i  in  1  TX word available.
tx_ready_o  out  1  one-cycle pop strobe.
tx_data_i  in  32  TX word, right-aligned.
rx_valid_o  out  1  RX word held.
rx_ready_i  in  1  RX consumer accepts.
rx_data_o  out  32  RX word, right-aligned, zero-extended.
busy_o  out  1  frame in progress.
ovr_o  out  1  overrun pulse.
udr_o  out  1  underrun pulse.
fre_o  out  1  frame-error pulse.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops: NSS to 1, SCK and MOSI to 0.
  - FSM in IDLE.
- Edge detection:
  - sck_s is the synchronised SCK; sck_q is sck_s delayed by one cycle.
  - rise = sck_s & ~sck_q; fall = ~sck_s & sck_q.
  - Leading edge = rise if cpol=0, fall if cpol=1. Trailing edge is the opposite.
  - Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge is the other one.
  - MOSI is sampled from its synchroniser output, which has the same latency as SCK.
- Configuration latch: cpol, cpha, lsb and dtb are latched on frame start and are stable for the whole frame.
- Word length: len = 8*(dtb+1). The bit counter is 5 bits and wraps to 0 after bit len-1.
- FSM states:
  - IDLE -> LOAD when en_i=1 and synchronised NSS falls.
  - LOAD (1 cycle) -> SHIFT: fetch the TX word.
    - If tx_valid_i: capture tx_data_i and pulse tx_ready_o.
    - Otherwise: load 0 and pulse udr_o.
  - SHIFT:
    - Sample edge: shift the MOSI bit into rx_sr.
      - lsb=0: enters at bit 0.
      - lsb=1: enters at bit len-1, shifting right.
      - The counter increments.
    - Shift edge: advance the TX bit index.
    - On the sample edge of bit len-1, the word is complete:
      - If rx_valid_o=0, rx_data_o <= assembled word and rx_valid_o <= 1.
      - If rx_valid_o=1 (not yet accepted), the word is dropped and ovr_o pulses.
      - Then fetch the next TX word with the same rule as LOAD, applied at the next shift edge.
  - Any state -> IDLE when synchronised NSS rises or en_i falls.
    - If bit counter != 0, pulse fre_o and discard the partial RX word.
    - Any fetched TX word is lost.
- MISO output:
  - spi_miso_o = txw[len-1-idx] (msb-first) or txw[idx] (lsb-first).
  - Registered; updates in LOAD and on shift edges.
  - cpha=0: the first bit is valid from the LOAD+1 cycle, before the first leading edge.
  - cpha=1: the first bit is driven at the first leading edge.
  - spi_miso_en_o = 1 while not in IDLE.
- RX handshake: rx_valid_o clears the cycle after rx_valid_o & rx_ready_i. A completion in that same cycle is accepted, not an overrun.
- busy_o = 1 in LOAD and SHIFT.
- Timing: ovr_o, udr_o and fre_o are single-cycle pulses. Latency from the last sample SCK edge at the pin to rx_valid_o is SYNC_STAGES+2 cycles.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Optional Feature:
- Macro: SPI_SLV_CRC8_EN.
- When defined:
  - Adds output crc_o[7:0], with reset value 0.
  - Computes CRC-8 (poly 0x07, init 0x00) over every sampled MOSI bit, in wire order, within a frame.
  - Cleared on LOAD; held in IDLE after NSS rises.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Mode 0, dtb=0, msb-first. Master sends 0xA5; TX FIFO holds 0x3C. Required: rx_data_o=0x000000A5, rx_valid_o=1, MISO bit stream 0,0,1,1,1,1,0,0, tx_ready_o pulses once.
- Mode 3, dtb=3, lsb=1. Master sends 0x12345678. Required: rx_data_o=0x12345678, and MISO matches tx_data_i 0xDEADBEEF LSB-first.
- Two 8-bit words with rx_ready_i held 0. Required: first word retained, ovr_o pulses once, rx_data_o unchanged.
- tx_valid_i=0 at frame start. Required: udr_o pulses, MISO all zeros for 8 bits, RX still captured.
- NSS deasserted after 5 SCK edges of a 16-bit word. Required: fre_o pulse, rx_valid_o stays 0, FSM returns to IDLE, spi_miso_en_o=0.
- With SPI_SLV_CRC8_EN defined, send 0x31 (mode 0). Required: crc_o=0x97.
